// File: rtl/alarm_responder_if.sv
// Bundle of alarm_responder inputs (sensor, time base, caregiver, alarm FSM) and indicator outputs.
// master drives the stimulus side; slave is the responder itself.
interface alarm_responder_if;
  logic       sw;
  logic       vital_hi;
  logic       tick;
  logic       ack_btn;
  logic       enchange_al;
  logic       alarm;
  logic       history;
  logic       change;
  logic       buzzer;
  logic       led;
  logic       page;
  logic [3:0] alarm_cnt;

  modport master (
    output sw, vital_hi, tick, ack_btn, enchange_al,
    input  alarm, history, change, buzzer, led, page, alarm_cnt
  );

  modport slave (
    input  sw, vital_hi, tick, ack_btn, enchange_al,
    output alarm, history, change, buzzer, led, page, alarm_cnt
  );
endinterface

// File: rtl/alarm_responder.sv
// Post-op vital alarm pulse, alarm history window and escalate/page/acknowledge FSM; all outputs registered (1 cycle).
// No backpressure: level/strobe inputs are sampled every cycle. Define ALARM_COUNT_EN for the saturating alarm_cnt.
module alarm_responder #(
  parameter int HIST_WIN    = 30,
  parameter int ACK_TIMEOUT = 60
) (
  input logic              clk,
  input logic              rst,
  alarm_responder_if.slave bus
);
  localparam int HW = $clog2(HIST_WIN + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {OFF, WATCH, ESCALATED, PAGING} state_t;

  state_t        state_q;
  logic          vital_q;
  logic          ack_q;
  logic          alarm_q;
  logic          change_q;
  logic          buzzer_q;
  logic          led_q;
  logic          page_q;
  logic [HW-1:0] hist_cnt_q;
  logic [HW-1:0] hist_cnt_d;
  logic [TW-1:0] tmo_cnt_q;
  logic          vital_rise;
  logic          ack_rise;

  assign vital_rise = bus.sw & bus.vital_hi & ~vital_q;
  assign ack_rise   = bus.ack_btn & ~ack_q;

  // Reload on the cycle the pulse is visible, so the pulse itself sees only earlier alarms.
  always_comb begin
    hist_cnt_d = hist_cnt_q;
    if (!bus.sw) begin
      hist_cnt_d = '0;
    end else if (alarm_q) begin
      hist_cnt_d = HW'(HIST_WIN);
    end else if (bus.tick && hist_cnt_q != '0) begin
      hist_cnt_d = hist_cnt_q - HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vital_q    <= 1'b0;
      ack_q      <= 1'b0;
      alarm_q    <= 1'b0;
      hist_cnt_q <= '0;
    end else begin
      vital_q    <= bus.vital_hi;
      ack_q      <= bus.ack_btn;
      alarm_q    <= vital_rise;
      hist_cnt_q <= hist_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= OFF;
      tmo_cnt_q <= '0;
      change_q  <= 1'b0;
      buzzer_q  <= 1'b0;
      led_q     <= 1'b0;
      page_q    <= 1'b0;
    end else begin
      change_q <= 1'b0;
      if (!bus.sw) begin
        state_q   <= OFF;
        tmo_cnt_q <= '0;
        buzzer_q  <= 1'b0;
        led_q     <= 1'b0;
        page_q    <= 1'b0;
      end else begin
        case (state_q)
          OFF: state_q <= WATCH;
          WATCH: begin
            if (bus.enchange_al) begin
              state_q   <= ESCALATED;
              tmo_cnt_q <= '0;
              buzzer_q  <= 1'b1;
              led_q     <= 1'b0;
            end
          end
          ESCALATED, PAGING: begin
            // An ack edge wins over both a coincident timeout and a dropped request.
            if (ack_rise || !bus.enchange_al) begin
              change_q <= ack_rise;
              state_q  <= WATCH;
              buzzer_q <= 1'b0;
              led_q    <= 1'b0;
              page_q   <= 1'b0;
            end else if (state_q == ESCALATED && bus.tick) begin
              if (tmo_cnt_q == TW'(ACK_TIMEOUT - 1)) begin
                state_q <= PAGING;
                page_q  <= 1'b1;
                led_q   <= 1'b1;
              end else begin
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
                led_q     <= ~led_q;
              end
            end
          end
          default: state_q <= OFF;
        endcase
      end
    end
  end

`ifdef ALARM_COUNT_EN
  logic [3:0] alarm_cnt_q;
  logic [3:0] alarm_cnt_d;

  always_comb begin
    alarm_cnt_d = alarm_cnt_q;
    if (!bus.sw) begin
      alarm_cnt_d = '0;
    end else if (vital_rise && alarm_cnt_q != 4'd15) begin
      alarm_cnt_d = alarm_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_cnt_q <= '0;
    end else begin
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  assign bus.alarm_cnt = alarm_cnt_q;
`else
  assign bus.alarm_cnt = 4'd0;
`endif

  assign bus.alarm   = alarm_q;
  assign bus.history = (hist_cnt_q != '0);
  assign bus.change  = change_q;
  assign bus.buzzer  = buzzer_q;
  assign bus.led     = led_q;
  assign bus.page    = page_q;
endmodule

// File: doc/alarm_responder.md
ALARM_RESPONDER -- requirements
Module: alarm_responder

Interface
REQ-001 SHALL have parameter HIST_WIN, default 30: number of tick strobes a prior alarm stays in history.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 60: number of tick strobes in ESCALATED before paging.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 SHALL have port sw  input  1  post-op monitoring enable.
REQ-006 SHALL have port vital_hi  input  1  vital-sign threshold exceeded, level, synchronous to clk.
REQ-007 SHALL have port tick  input  1  one-cycle time-base strobe.
REQ-008 SHALL have port ack_btn  input  1  caregiver acknowledge, level, synchronous to clk.
REQ-009 SHALL have port enchange_al  input  1  escalated-alarm request from the alarm FSM.
REQ-010 SHALL have port alarm  output  1  one-cycle alarm event pulse to the alarm FSM.
REQ-011 SHALL have port history  output  1  a prior alarm occurred within the history window.
REQ-012 SHALL have port change  output  1  one-cycle acknowledge pulse to the alarm FSM.
REQ-013 SHALL have ports buzzer, led, page  output  1 each  caregiver indicators.
REQ-014 SHALL have port alarm_cnt  output  4  alarm event count.

Function
REQ-015 SHALL register vital_hi and ack_btn once (vital_q, ack_q) for rising-edge detection.
REQ-016 SHALL drive alarm, as a registered output, high for exactly one cycle after any cycle with sw=1, vital_hi=1, vital_q=0.
REQ-017 SHALL keep a hist_cnt counter wide enough for HIST_WIN: reload to HIST_WIN on the alarm-pulse edge, decrement on tick while nonzero; reload wins over a coincident tick.
REQ-018 SHALL drive history = (hist_cnt != 0), so history is 0 on the first alarm pulse and 1 on a second pulse inside the window.
REQ-019 SHALL implement FSM states OFF, WATCH, ESCALATED, PAGING.
REQ-020 SHALL transition: OFF->WATCH when sw=1; any state->OFF when sw=0 (sw=0 has highest priority).
REQ-021 SHALL transition WATCH->ESCALATED when enchange_al=1, clearing the timeout counter.
REQ-022 SHALL, in ESCALATED, count tick strobes and enter PAGING on the tick that reaches ACK_TIMEOUT.
REQ-023 SHALL, in ESCALATED or PAGING, on ack_btn=1 with ack_q=0: pulse change for exactly one cycle (next edge) and return to WATCH.
REQ-024 SHALL return ESCALATED/PAGING->WATCH without a change pulse if enchange_al falls with no ack edge.
REQ-025 SHALL give an ack edge priority over a coincident timeout: change pulse, go to WATCH, no PAGING.
REQ-026 SHALL suppress change when sw=0 in the same cycle as an ack edge.
REQ-027 SHALL drive buzzer=1 in ESCALATED and PAGING only; page=1 in PAGING only.
REQ-028 SHALL toggle led on each tick in ESCALATED, hold led=1 in PAGING, and drive led=0 in OFF and WATCH.
REQ-029 SHALL, while sw=0, clear hist_cnt, the timeout counter and alarm_cnt, and suppress alarm.

Reset
REQ-030 SHALL, on rst=0, set state=OFF and alarm=history=change=buzzer=led=page=0, alarm_cnt=0, all counters and vital_q, ack_q = 0.
REQ-031 SHALL, on reset asserted mid-escalation, produce no change pulse, and after release resume from OFF.

Configuration
REQ-032 SHALL, with ALARM_COUNT_EN defined, increment alarm_cnt by 1 on each alarm pulse, saturating at 15.
REQ-033 SHALL, without ALARM_COUNT_EN, tie alarm_cnt to 0 and include no counter logic; all other behaviour is unchanged.

Verification (HIST_WIN=4, ACK_TIMEOUT=3)
REQ-034 SHALL check: sw=1, vital_hi 0->1 -> alarm=1 for one cycle with history=0; alarm_cnt=1 if ALARM_COUNT_EN.
REQ-035 SHALL check: second vital_hi rise after 2 ticks -> alarm pulse with history=1; after 4 more ticks with no rise, history=0.
REQ-036 SHALL check: enchange_al=1 -> buzzer=1, led toggles per tick; after 3 ticks without ack -> page=1, led=1.
REQ-037 SHALL check: in PAGING, ack_btn 0->1 -> change=1 for exactly one cycle, buzzer=page=0, state WATCH.
REQ-038 SHALL check: ack edge on the same cycle as the third tick -> change pulse, page stays 0.
REQ-039 SHALL check: rst=0 during ESCALATED -> all outputs 0 immediately, no change pulse; sw=0 with ack edge -> change=0, alarm_cnt=0.
